// File: rtl/mem_ctrl.sv
// M-stage memory access controller: turns load/store requests into a single
// registered bus transaction and formats the returned load data.
module mem_ctrl #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        m_load,
   input  logic        m_wr,
   input  logic [31:0] m_addr,
   input  logic [31:0] m_wdata,
   input  logic [2:0]  m_opt,
   input  logic        m_signed,
   output logic        m_stall,
   output logic [31:0] m_rdata,
   output logic        m_rdata_valid,
   output logic        m_fault,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_wstrb,
   output logic [31:0] bus_wdata,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata
);

   localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_REQ   = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;
   localparam logic [1:0] S_FAULT = 2'd3;

   logic [1:0]    r_state;
   logic [CW-1:0] r_cnt;
   logic          r_is_load;
   logic [1:0]    r_off;
   logic [1:0]    r_opt;
   logic          r_signed;

   logic          w_request;
   logic          w_illegal;
   logic          w_timeout;
   logic [31:0]   w_wdata_b;
   logic [3:0]    w_strb_b;
   logic [31:0]   w_wdata;
   logic [3:0]    w_wstrb;
   logic [31:0]   w_shift;
   logic [31:0]   w_load;

   assign w_request = m_load | m_wr;
   assign w_illegal = (m_opt > 3'd2)
                    | ((m_opt == 3'd1) & m_addr[0])
                    | ((m_opt == 3'd2) & (m_addr[1:0] != 2'b00));
   assign w_timeout = (r_cnt == CW'(TIMEOUT - 1));

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         assign w_wdata_b[gi*8 +: 8] = m_wdata[7:0];
         assign w_strb_b[gi]         = (m_addr[1:0] == 2'(gi));
      end
   endgenerate

   always_comb begin
      w_wdata = m_wdata;
      w_wstrb = 4'b1111;
      case (m_opt[1:0])
         2'd0: begin
            w_wdata = w_wdata_b;
            w_wstrb = w_strb_b;
         end
         2'd1: begin
            w_wdata = {2{m_wdata[15:0]}};
            w_wstrb = m_addr[1] ? 4'b1100 : 4'b0011;
         end
         default: ;
      endcase
   end

   // Load formatting uses the offset/size captured at request time.
   assign w_shift = bus_rdata >> {r_off, 3'b000};

   always_comb begin
      w_load = w_shift;
      case (r_opt)
         2'd0:    w_load = {{24{r_signed & w_shift[7]}}, w_shift[7:0]};
         2'd1:    w_load = {{16{r_signed & w_shift[15]}}, w_shift[15:0]};
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_is_load <= 1'b0;
         r_off     <= 2'd0;
         r_opt     <= 2'd0;
         r_signed  <= 1'b0;
         bus_req   <= 1'b0;
         bus_we    <= 1'b0;
         bus_addr  <= 32'd0;
         bus_wstrb <= 4'd0;
         bus_wdata <= 32'd0;
         m_rdata   <= 32'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_request) begin
                  if (w_illegal) begin
                     r_state <= S_FAULT;
                  end else begin
                     r_state   <= S_REQ;
                     r_cnt     <= '0;
                     r_is_load <= ~m_wr;
                     r_off     <= m_addr[1:0];
                     r_opt     <= m_opt[1:0];
                     r_signed  <= m_signed;
                     bus_req   <= 1'b1;
                     bus_we    <= m_wr;
                     bus_addr  <= {m_addr[31:2], 2'b00};
                     bus_wstrb <= m_wr ? w_wstrb : 4'd0;
                     bus_wdata <= m_wr ? w_wdata : 32'd0;
                  end
               end
            end
            S_REQ: begin
               // ack takes priority over a timeout landing in the same cycle
               if (bus_ack) begin
                  r_state <= S_DONE;
                  bus_req <= 1'b0;
                  if (r_is_load) m_rdata <= w_load;
               end else if (w_timeout) begin
                  r_state <= S_FAULT;
                  bus_req <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign m_stall       = ((r_state == S_IDLE) & w_request) | (r_state == S_REQ);
   assign m_rdata_valid = (r_state == S_DONE) & r_is_load;
   assign m_fault       = (r_state == S_FAULT);

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with TIMEOUT = 4; expected values hand-computed.
module tb_mem_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        m_load, m_wr, m_signed;
   logic [31:0] m_addr, m_wdata;
   logic [2:0]  m_opt;
   logic        m_stall, m_rdata_valid, m_fault;
   logic [31:0] m_rdata;
   logic        bus_req, bus_we, bus_ack;
   logic [31:0] bus_addr, bus_wdata, bus_rdata;
   logic [3:0]  bus_wstrb;

   int n_checks = 0;
   int n_fail   = 0;
   int cnt_stall = 0, cnt_valid = 0, cnt_fault = 0;
   int snap_stall, snap_valid, snap_fault;

   mem_ctrl #(.TIMEOUT(4)) dut (
      .clk(clk), .rst(rst),
      .m_load(m_load), .m_wr(m_wr), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_opt(m_opt), .m_signed(m_signed),
      .m_stall(m_stall), .m_rdata(m_rdata), .m_rdata_valid(m_rdata_valid),
      .m_fault(m_fault),
      .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
      .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
      .bus_ack(bus_ack), .bus_rdata(bus_rdata)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (m_stall === 1'b1)       cnt_stall++;
      if (m_rdata_valid === 1'b1) cnt_valid++;
      if (m_fault === 1'b1)       cnt_fault++;
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic snap();
      snap_stall = cnt_stall;
      snap_valid = cnt_valid;
      snap_fault = cnt_fault;
   endtask

   task automatic issue(input logic ld, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [2:0] opt, input logic sg);
      m_load = ld; m_wr = wr; m_addr = addr; m_wdata = wd; m_opt = opt; m_signed = sg;
      #1;
      $display("txn: load=%0b wr=%0b addr=0x%08h wdata=0x%08h opt=%0d signed=%0b",
               ld, wr, addr, wd, opt, sg);
   endtask

   task automatic idle_inputs();
      m_load = 1'b0; m_wr = 1'b0;
   endtask

   initial begin
      rst = 1'b1; m_load = 0; m_wr = 0; m_addr = 0; m_wdata = 0; m_opt = 0; m_signed = 0;
      bus_ack = 0; bus_rdata = 0;
      #12;
      check("rst_bus_req", 32'(bus_req), 32'd0);
      check("rst_m_rdata", m_rdata, 32'd0);
      check("rst_bus_addr", bus_addr, 32'd0);
      check("rst_valid_fault", {30'd0, m_rdata_valid, m_fault}, 32'd0);
      check("rst_stall", 32'(m_stall), 32'd0);
      tick();
      rst = 1'b0;
      tick();

      // Signed byte load, ack in 2nd REQ cycle
      snap();
      issue(1, 0, 32'h0000_1003, 32'd0, 3'd0, 1);
      check("sb_stall_idle", 32'(m_stall), 32'd1);
      tick();
      check("sb_bus_req", 32'(bus_req), 32'd1);
      check("sb_bus_addr", bus_addr, 32'h0000_1000);
      check("sb_wstrb_we", {27'd0, bus_we, bus_wstrb}, 32'd0);
      tick();
      bus_ack = 1; bus_rdata = 32'h80FF_FFFF;
      tick();
      bus_ack = 0; bus_rdata = 32'd0;
      check("sb_valid", 32'(m_rdata_valid), 32'd1);
      check("sb_rdata", m_rdata, 32'hFFFF_FF80);
      check("sb_stall_done", 32'(m_stall), 32'd0);
      check("sb_req_done", 32'(bus_req), 32'd0);
      idle_inputs();
      tick();
      check("sb_valid_off", 32'(m_rdata_valid), 32'd0);
      check("sb_stall_cycles", 32'(cnt_stall - snap_stall), 32'd3);
      check("sb_valid_pulses", 32'(cnt_valid - snap_valid), 32'd1);

      // Halfword store at upper half
      issue(0, 1, 32'h0000_2002, 32'h1234_ABCD, 3'd1, 0);
      tick();
      check("sh_wdata", bus_wdata, 32'hABCD_ABCD);
      check("sh_wstrb", 32'(bus_wstrb), 32'h0000_000C);
      check("sh_we", 32'(bus_we), 32'd1);
      check("sh_addr", bus_addr, 32'h0000_2000);
      bus_ack = 1; bus_rdata = 32'hDEAD_BEEF;
      tick();
      bus_ack = 0;
      check("sh_valid", 32'(m_rdata_valid), 32'd0);
      check("sh_rdata_kept", m_rdata, 32'hFFFF_FF80);
      idle_inputs();
      tick();

      // Byte store at lane 3
      issue(0, 1, 32'h0000_7003, 32'h0000_00EE, 3'd0, 0);
      tick();
      check("sbst_wdata", bus_wdata, 32'hEEEE_EEEE);
      check("sbst_wstrb", 32'(bus_wstrb), 32'h0000_0008);
      bus_ack = 1;
      tick();
      bus_ack = 0; idle_inputs();
      tick();

      // Misaligned word load -> fault, no bus access
      snap();
      issue(1, 0, 32'h0000_3001, 32'd0, 3'd2, 0);
      check("mis_stall", 32'(m_stall), 32'd1);
      check("mis_req", 32'(bus_req), 32'd0);
      tick();
      check("mis_fault", 32'(m_fault), 32'd1);
      check("mis_req_fault", 32'(bus_req), 32'd0);
      check("mis_stall_fault", 32'(m_stall), 32'd0);
      idle_inputs();
      tick();
      check("mis_fault_off", 32'(m_fault), 32'd0);
      check("mis_stall_cycles", 32'(cnt_stall - snap_stall), 32'd1);
      check("mis_fault_pulses", 32'(cnt_fault - snap_fault), 32'd1);

      // Illegal size code
      issue(1, 0, 32'h0000_3000, 32'd0, 3'd3, 0);
      tick();
      check("ill_fault", 32'(m_fault), 32'd1);
      idle_inputs();
      tick();

      // Timeout without ack: bus_req high 4 cycles then fault
      issue(1, 0, 32'h0000_4000, 32'd0, 3'd2, 0);
      for (int i = 0; i < 4; i++) begin
         tick();
         check($sformatf("to_req_c%0d", i), {30'd0, bus_req, m_fault}, 32'd2);
      end
      tick();
      check("to_fault", {30'd0, bus_req, m_fault}, 32'd1);
      idle_inputs();
      tick();
      check("to_idle", 32'(m_fault), 32'd0);

      // Ack on the 4th REQ cycle wins over the timeout
      snap();
      issue(1, 0, 32'h0000_4000, 32'd0, 3'd2, 0);
      for (int i = 0; i < 3; i++) tick();
      tick();
      bus_ack = 1; bus_rdata = 32'hCAFE_F00D;
      tick();
      bus_ack = 0;
      check("tw_valid", 32'(m_rdata_valid), 32'd1);
      check("tw_rdata", m_rdata, 32'hCAFE_F00D);
      idle_inputs();
      tick();
      check("tw_no_fault", 32'(cnt_fault - snap_fault), 32'd0);

      // Signed halfword load from upper half
      issue(1, 0, 32'h0000_8002, 32'd0, 3'd1, 1);
      tick();
      bus_ack = 1; bus_rdata = 32'h8001_0000;
      tick();
      bus_ack = 0; idle_inputs();
      check("shl_rdata", m_rdata, 32'hFFFF_8001);
      tick();

      // Reset in REQ drops bus_req immediately; late ack ignored
      issue(1, 0, 32'h0000_5000, 32'd0, 3'd2, 0);
      tick();
      check("ra_req", 32'(bus_req), 32'd1);
      #1 rst = 1'b1;
      #1;
      check("ra_req_async", 32'(bus_req), 32'd0);
      check("ra_rdata_clr", m_rdata, 32'd0);
      idle_inputs();
      tick();
      #2 rst = 1'b0;
      snap();
      tick();
      bus_ack = 1; bus_rdata = 32'h1111_1111;
      tick();
      bus_ack = 0;
      tick();
      tick();
      check("ra_no_pulse", 32'(cnt_valid - snap_valid + cnt_fault - snap_fault), 32'd0);
      check("ra_rdata_kept", m_rdata, 32'd0);

      // Back-to-back load then store
      issue(1, 0, 32'h0000_6001, 32'd0, 3'd0, 0);
      tick();
      bus_ack = 1; bus_rdata = 32'h0000_A500;
      tick();
      bus_ack = 0;
      check("bb_valid", 32'(m_rdata_valid), 32'd1);
      check("bb_rdata", m_rdata, 32'h0000_00A5);
      issue(0, 1, 32'h0000_6004, 32'h1122_3344, 3'd2, 0);
      check("bb_stall_done", 32'(m_stall), 32'd0);
      check("bb_req_done", 32'(bus_req), 32'd0);
      tick();
      check("bb_idle_gap", {30'd0, bus_req, m_stall}, 32'd1);
      tick();
      check("bb_req2", 32'(bus_req), 32'd1);
      check("bb_wdata2", bus_wdata, 32'h1122_3344);
      check("bb_wstrb2", 32'(bus_wstrb), 32'h0000_000F);
      check("bb_addr2", bus_addr, 32'h0000_6004);
      bus_ack = 1;
      tick();
      bus_ack = 0; idle_inputs();
      check("bb_rdata_kept", m_rdata, 32'h0000_00A5);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
